// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode codes, burst FSM
// states and the single-step next-value function used by every update path.
package shift_reg_pkg;

  localparam int unsigned MODE_W = 3;
  localparam int unsigned MAX_W  = 64;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_ASR  = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } burst_state_e;

  // One operation on a width-bit value carried zero-extended in MAX_W bits.
  function automatic logic [MAX_W-1:0] next_q(
    input logic [MAX_W-1:0]  q,
    input logic [MODE_W-1:0] mode,
    input logic [MAX_W-1:0]  d,
    input logic              sin_l,
    input logic              sin_r,
    input int unsigned       width
  );
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] msb_bit;
    logic [MAX_W-1:0] res;
    logic             msb;
    mask    = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    msb_bit = MAX_W'(1) << (width - 1);
    msb     = q[6'(width - 1)];
    res     = q;
    case (mode)
      MODE_SHL:  res = (q << 1) | MAX_W'(sin_r);
      MODE_SHR:  res = (q >> 1) | (sin_l ? msb_bit : '0);
      MODE_LOAD: res = d;
      MODE_ROL:  res = (q << 1) | MAX_W'(msb);
      MODE_ROR:  res = (q >> 1) | (q[0] ? msb_bit : '0);
      MODE_ASR:  res = (q >> 1) | (msb ? msb_bit : '0);
      default:   res = q;
    endcase
    return res & mask;
  endfunction

endpackage

// File: rtl/shift_burst_ctrl.sv
// Burst sequencer: owns the step counter, IDLE/RUN FSM, busy and done, and
// tells the datapath when to step and with which mode.
module shift_burst_ctrl
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              step_en_c,
  output logic [MODE_W-1:0] step_mode_c
);

  burst_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              done_q, done_d;
  logic              start_ok_c;

  // A start is only honoured for counts in 1..WIDTH.
  assign start_ok_c = start && (count != '0) && (count <= CNT_W'(WIDTH));

  // Next-state, counter and step strobe; the first burst step shares the start edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    done_d      = 1'b0;
    step_en_c   = 1'b0;
    step_mode_c = mode;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_c) begin
          step_en_c = 1'b1;
          mode_d    = mode;
          cnt_d     = count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else if (en) begin
          step_en_c = 1'b1;
        end
      end
      ST_RUN: begin
        step_en_c   = 1'b1;
        step_mode_c = mode_q;
        cnt_d       = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;

endmodule

// File: rtl/shift_reg_universal.sv
// WIDTH-bit universal shift register with single-step and burst operation.
// Optional registered parity output enabled by SHIFT_REG_UNIVERSAL_PARITY_EN.
module shift_reg_universal
  import shift_reg_pkg::*;
#(
  parameter int unsigned  WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin_l,
  input  logic              sin_r,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  output logic [WIDTH-1:0]  q,
  output logic              sout_msb,
  output logic              sout_lsb,
  output logic              busy,
  output logic              done
`ifdef SHIFT_REG_UNIVERSAL_PARITY_EN
  ,
  output logic              parity
`endif
);

  logic [WIDTH-1:0]  q_q, q_d;
  logic              step_en_c;
  logic [MODE_W-1:0] step_mode_c;

  shift_burst_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .mode        (mode),
    .start       (start),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .step_en_c   (step_en_c),
    .step_mode_c (step_mode_c)
  );

  // Apply the selected operation whenever the controller strobes a step.
  always_comb begin
    q_d = q_q;
    if (step_en_c) begin
      q_d = WIDTH'(next_q(MAX_W'(q_q), step_mode_c, MAX_W'(d), sin_l, sin_r, WIDTH));
    end
  end

  // Data register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

`ifdef SHIFT_REG_UNIVERSAL_PARITY_EN
  logic parity_q;

  // Parity of the value being written, aligned with q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^q_d;
    end
  end

  assign parity = parity_q;
`endif

  assign q        = q_q;
  assign sout_msb = q_q[WIDTH-1];
  assign sout_lsb = q_q[0];

endmodule
